compressor_ingress_ctrl: RTL and testbench

Parametrised ingress controller for the compression path: accepts an AXI-Stream-style beat stream and pushes every accepted beat into the compressor input FIFO. It classifies each packet on its first beat using programmable value/mask matches, and drives per-beat header/compression tags and the FIFO pop request. It maintains saturating packet statistics, including truncated-header (runt) detection. It generalises the fixed 256-bit, 4-header-beat, hard-coded-TCP-match controller in width, header length and match rule.

---
 rtl/compressor_ingress_ctrl.sv | 90 +++++++++
 tb/tb_compressor_ingress_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/compressor_ingress_ctrl.sv
// compressor_ingress_ctrl: classifies packets on their first beat, tags beats and keeps saturating packet statistics
module compressor_ingress_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int HDR_BEATS  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] hdr_value,
  input  logic [DATA_WIDTH-1:0] hdr_mask,
  input  logic [DATA_WIDTH-1:0] cmp_value,
  input  logic [DATA_WIDTH-1:0] cmp_mask,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic                  pop_ready,
  output logic                  fifo_push,
  output logic                  fifo_pop,
  output logic [1:0]            state,
  output logic [3:0]            beat_idx,
  output logic                  flag_compression,
  output logic                  is_header,
  input  logic                  clear_counts,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  cmp_count,
  output logic [CNT_WIDTH-1:0]  runt_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;
  localparam bit MULTI = HDR_BEATS > 1;
  state_t st, st_n;
  logic [3:0] idx_n;
  logic flag_q, xfer, first, hdr_hit, cmp_hit, last_hdr, runt;
  assign s_tready  = !fifo_full;
  assign xfer      = s_tvalid & s_tready;
  assign fifo_push = xfer;
  assign fifo_pop  = !fifo_empty & pop_ready;
  assign hdr_hit   = ~|((s_tdata ^ hdr_value) & hdr_mask);
  assign cmp_hit   = ~|((s_tdata ^ cmp_value) & cmp_mask);
  assign first     = xfer && st == IDLE;
  assign last_hdr  = beat_idx == 4'(HDR_BEATS - 1);
  assign state     = st;
  assign flag_compression = first ? enable & hdr_hit & cmp_hit : flag_q;
  assign idx_n = !xfer ? beat_idx : s_tlast ? 4'd0 : (&beat_idx) ? beat_idx : beat_idx + 4'd1;
  always_comb begin
    st_n      = st;
    is_header = 1'b0;
    runt      = 1'b0;
    if (first) begin
      is_header = hdr_hit;
      st_n      = s_tlast ? IDLE : (hdr_hit && MULTI) ? HDR : DATA;
      runt      = hdr_hit && s_tlast && MULTI;
    end else if (xfer && st == HDR) begin
      is_header = 1'b1;
      st_n      = s_tlast ? IDLE : last_hdr ? DATA : HDR;
      runt      = s_tlast && !last_hdr;
    end else if (xfer && st == DATA && s_tlast) begin
      st_n = IDLE;
    end
  end
  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + CNT_WIDTH'(1) : c;
  endfunction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      beat_idx   <= '0;
      flag_q     <= 1'b0;
      pkt_count  <= '0;
      cmp_count  <= '0;
      runt_count <= '0;
    end else begin
      st       <= st_n;
      beat_idx <= idx_n;
      flag_q   <= flag_compression;
      if (clear_counts) begin
        pkt_count  <= '0;
        cmp_count  <= '0;
        runt_count <= '0;
      end else begin
        pkt_count  <= bump(pkt_count, first);
        cmp_count  <= bump(cmp_count, first & flag_compression);
        runt_count <= bump(runt_count, runt);
      end
    end
  end
endmodule

// File: tb/tb_compressor_ingress_ctrl.sv
// tb_compressor_ingress_ctrl: directed packets checked every cycle against a packet-level model
module tb_compressor_ingress_ctrl;
  localparam int DW = 256, HB = 4, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, reset = 1, enable = 1, s_tvalid = 0, s_tlast = 0;
  logic [DW-1:0] s_tdata = '0, hdr_value = '0, hdr_mask = '0, cmp_value = '0, cmp_mask = '0;
  logic fifo_full = 0, fifo_empty = 1, pop_ready = 0, clear_counts = 0;
  logic s_tready, fifo_push, fifo_pop, flag_compression, is_header;
  logic [1:0] state;
  logic [3:0] beat_idx;
  logic [CW-1:0] pkt_count, cmp_count, runt_count;
  int checks = 0, failures = 0, k = 0;

  compressor_ingress_ctrl #(.DATA_WIDTH(DW), .HDR_BEATS(HB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tready(s_tready), .hdr_value(hdr_value), .hdr_mask(hdr_mask),
    .cmp_value(cmp_value), .cmp_mask(cmp_mask), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .pop_ready(pop_ready), .fifo_push(fifo_push), .fifo_pop(fifo_pop), .state(state),
    .beat_idx(beat_idx), .flag_compression(flag_compression), .is_header(is_header),
    .clear_counts(clear_counts), .pkt_count(pkt_count), .cmp_count(cmp_count),
    .runt_count(runt_count));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // model: beats accepted so far in the current packet, its class, and plain integer counters
  int m_beat, m_pkt, m_cmp, m_runt;
  bit m_hp, m_flag;
  function automatic bit hm();
    return ((s_tdata ^ hdr_value) & hdr_mask) == '0;
  endfunction
  function automatic bit cm();
    return ((s_tdata ^ cmp_value) & cmp_mask) == '0;
  endfunction
  function automatic int sat(input int v);
    return v > CMAX ? CMAX : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_beat = 0; m_hp = 0; m_flag = 0; m_pkt = 0; m_cmp = 0; m_runt = 0;
    end else begin
      if (s_tvalid && !fifo_full) begin
        if (m_beat == 0) begin
          m_hp = hm();
          m_flag = enable && m_hp && cm();
          m_pkt = sat(m_pkt + 1);
          if (m_flag) m_cmp = sat(m_cmp + 1);
        end
        if (m_hp && s_tlast && m_beat < HB - 1) m_runt = sat(m_runt + 1);
        m_beat = s_tlast ? 0 : m_beat + 1;
      end
      if (clear_counts) begin
        m_pkt = 0; m_cmp = 0; m_runt = 0;
      end
    end
  end

  logic c_x, c_first;
  always @(negedge clk) begin
    c_x = s_tvalid && !fifo_full;
    c_first = c_x && m_beat == 0;
    chk("s_tready", s_tready, !fifo_full);
    chk("fifo_push", fifo_push, c_x);
    chk("fifo_pop", fifo_pop, !fifo_empty && pop_ready);
    chk("state", state, m_beat == 0 ? 0 : (m_hp && m_beat < HB) ? 1 : 2);
    chk("beat_idx", beat_idx, m_beat > 15 ? 15 : m_beat);
    chk("is_header", is_header, c_x && (m_beat == 0 ? hm() : (m_hp && m_beat < HB)));
    chk("flag", flag_compression, c_first ? (enable && hm() && cm()) : m_flag);
    chk("pkt_count", pkt_count, m_pkt);
    chk("cmp_count", cmp_count, m_cmp);
    chk("runt_count", runt_count, m_runt);
  end

  function automatic logic [DW-1:0] mk(input logic [7:0] p, input logic c);
    logic [DW-1:0] d;
    d = '0;
    d[191:184] = p;
    d[111:96] = c ? 16'h0008 : 16'h1234;
    d[31:0] = 32'hA5A5_0000 | 32'(k);
    return d;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic last, output logic ih, output logic fl);
    s_tvalid = 1; s_tdata = d; s_tlast = last;
    pop_ready = k[0]; fifo_empty = k[1]; k++;
    @(negedge clk);
    ih = is_header; fl = flag_compression;
    @(posedge clk); #1;
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic send_pkt(input logic [7:0] p, input logic c, input int n,
                          output logic [15:0] ihv, output logic [15:0] flv);
    logic ih, fl;
    ihv = '0; flv = '0;
    for (int i = 0; i < n; i++) begin
      send(mk(p, c), i == n - 1, ih, fl);
      ihv[i] = ih; flv[i] = fl;
    end
  endtask

  logic [15:0] ihv, flv;
  logic ih, fl;
  initial begin
    hdr_mask[191:184] = 8'hFF;
    hdr_value[191:184] = 8'h06;
    cmp_mask[111:96] = 16'hFFFF;
    cmp_value[111:96] = 16'h0008;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_pkt", pkt_count, 0);
    @(posedge clk); #1 reset = 0;

    send_pkt(8'h06, 1, 6, ihv, flv);
    chk("p1_is_header", ihv[5:0], 6'b001111);
    chk("p1_flag", flv[5:0], 6'b111111);
    chk("p1_pkt", pkt_count, 1);
    chk("p1_cmp", cmp_count, 1);

    send(mk(8'h11, 1), 0, ih, fl);
    chk("p2_state_data", state, 2);
    chk("p2_ih_fl", {ih, fl}, 0);
    send(mk(8'h11, 1), 0, ih, fl);
    send(mk(8'h11, 1), 1, ih, fl);
    chk("p2_state_idle", state, 0);
    chk("p2_cmp", cmp_count, 1);

    send_pkt(8'h06, 1, 3, ihv, flv);
    chk("p3_runt", runt_count, 1);
    chk("p3_state", state, 0);
    send_pkt(8'h11, 0, 1, ihv, flv);
    chk("p3_next_ih", ihv[0], 0);
    chk("p3_pkt", pkt_count, 4);

    send(mk(8'h06, 0), 0, ih, fl);
    send(mk(8'h06, 0), 0, ih, fl);
    fifo_full = 1; s_tvalid = 1; s_tdata = mk(8'h06, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", s_tready, 0);
      chk("stall_push", fifo_push, 0);
      chk("stall_idx", beat_idx, 2);
      chk("stall_state", state, 1);
    end
    @(posedge clk); #1;
    fifo_full = 0; s_tvalid = 0;
    send(mk(8'h06, 0), 0, ih, fl);
    chk("p4_ih2", ih, 1);
    send(mk(8'h06, 0), 0, ih, fl);
    chk("p4_ih3", ih, 1);
    chk("p4_state", state, 2);
    send(mk(8'h06, 0), 1, ih, fl);
    chk("p4_ih4", ih, 0);
    chk("p4_runt", runt_count, 1);
    chk("p4_pkt", pkt_count, 5);

    enable = 0;
    send_pkt(8'h06, 1, 4, ihv, flv);
    chk("p5_ih", ihv[3:0], 4'b1111);
    chk("p5_flag", flv[3:0], 0);
    chk("p5_cmp", cmp_count, 2);
    enable = 1;
    clear_counts = 1;
    send(mk(8'h06, 1), 1, ih, fl);
    clear_counts = 0;
    chk("clr_pkt", pkt_count, 0);
    chk("clr_cmp", cmp_count, 0);
    chk("clr_runt", runt_count, 0);

    repeat (17) send(mk(8'h11, 0), 1, ih, fl);
    chk("sat_pkt", pkt_count, 15);
    send(mk(8'h11, 0), 0, ih, fl);
    send(mk(8'h11, 0), 0, ih, fl);
    chk("pre_rst_state", state, 2);
    reset = 1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_idx", beat_idx, 0);
    @(posedge clk); #1 reset = 0;
    send(mk(8'h06, 1), 1, ih, fl);
    chk("post_rst_ih", ih, 1);
    chk("post_rst_pkt", pkt_count, 1);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
